// File: rtl/move_engine.sv
// Othello move executor: checks the target cell, walks all eight rays in board RAM, flips flanked discs, then places the disc.
// Optional MOVE_ENGINE_FLIP_COUNT_EN adds a flip_count output reporting discs flipped by the last accepted move.
module move_engine (
  input  logic       clock,
  input  logic       reset,
  input  logic       new_move,
  input  logic       player,
  input  logic       place,
  input  logic [2:0] move_x,
  input  logic [2:0] move_y,
  output logic [5:0] board_addr,
  input  logic [1:0] board_rdata,
  output logic       board_we,
  output logic [1:0] board_wdata,
  output logic       ack,
  output logic       invalid,
  output logic       busy
`ifdef MOVE_ENGINE_FLIP_COUNT_EN
  ,
  output logic [5:0] flip_count
`endif
);

  typedef enum logic [3:0] {
    S_IDLE, S_TGT_RD, S_TGT_EV, S_STEP_RD, S_STEP_EV,
    S_FLIP, S_COMMIT, S_ACK, S_REJECT
  } state_t;

  state_t     state_q;
  logic [2:0] x_q, y_q, dir_q;
  logic [3:0] k_q;
  logic       player_q, any_flip_q;
  logic [5:0] addr_q;
  logic       we_q;
  logic [1:0] wdata_q;
  logic       ack_q, invalid_q;
`ifdef MOVE_ENGINE_FLIP_COUNT_EN
  logic [5:0] flip_cnt_q;
`endif

  logic [1:0] own_d, opp_d;
  logic       cur_ok_d, end_dir_d, any_flip_d;
  logic [5:0] first_addr_d, inc_addr_d, dec_addr_d, next_dir_addr_d;

  // Direction 0..7 = N, NE, E, SE, S, SW, W, NW; N decreases y.
  function automatic logic x_inc(input logic [2:0] dir);
    return (dir >= 3'd1) && (dir <= 3'd3);
  endfunction

  function automatic logic x_dec(input logic [2:0] dir);
    return dir >= 3'd5;
  endfunction

  function automatic logic y_inc(input logic [2:0] dir);
    return (dir >= 3'd3) && (dir <= 3'd5);
  endfunction

  function automatic logic y_dec(input logic [2:0] dir);
    return (dir == 3'd7) || (dir <= 3'd1);
  endfunction

  function automatic logic [2:0] walk3(input logic [2:0] b, input logic up, input logic dn,
                                       input logic [2:0] k);
    return up ? b + k : (dn ? b - k : b);
  endfunction

  // 4-bit walk: any result outside 0..7 (including wrapped negatives) lands at 8..15.
  function automatic logic walk_ok(input logic [2:0] b, input logic up, input logic dn,
                                   input logic [3:0] k);
    logic [3:0] p;
    p = up ? {1'b0, b} + k : (dn ? {1'b0, b} - k : {1'b0, b});
    return p < 4'd8;
  endfunction

  function automatic logic [5:0] step_addr(input logic [2:0] tx, input logic [2:0] ty,
                                           input logic [2:0] dir, input logic [2:0] k);
    return {walk3(ty, y_inc(dir), y_dec(dir), k), walk3(tx, x_inc(dir), x_dec(dir), k)};
  endfunction

  always_comb begin
    own_d           = player_q ? 2'b10 : 2'b01;
    opp_d           = player_q ? 2'b01 : 2'b10;
    cur_ok_d        = walk_ok(x_q, x_inc(dir_q), x_dec(dir_q), k_q) &&
                      walk_ok(y_q, y_inc(dir_q), y_dec(dir_q), k_q);
    first_addr_d    = step_addr(x_q, y_q, 3'd0, 3'd1);
    inc_addr_d      = step_addr(x_q, y_q, dir_q, k_q[2:0] + 3'd1);
    dec_addr_d      = step_addr(x_q, y_q, dir_q, k_q[2:0] - 3'd1);
    next_dir_addr_d = step_addr(x_q, y_q, dir_q + 3'd1, 3'd1);
    any_flip_d      = any_flip_q | (state_q == S_FLIP);
    end_dir_d       = 1'b0;
    case (state_q)
      S_STEP_RD: end_dir_d = !cur_ok_d;
      S_STEP_EV: end_dir_d = !((board_rdata == opp_d) ||
                               ((board_rdata == own_d) && (k_q >= 4'd2)));
      S_FLIP:    end_dir_d = (k_q == 4'd1);
      default:   end_dir_d = 1'b0;
    endcase
  end

  // Outputs are loaded together with the state they belong to, so they are valid during that state.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      x_q        <= 3'd0;
      y_q        <= 3'd0;
      dir_q      <= 3'd0;
      k_q        <= 4'd0;
      player_q   <= 1'b0;
      any_flip_q <= 1'b0;
      addr_q     <= 6'd0;
      we_q       <= 1'b0;
      wdata_q    <= 2'b00;
      ack_q      <= 1'b0;
      invalid_q  <= 1'b0;
`ifdef MOVE_ENGINE_FLIP_COUNT_EN
      flip_cnt_q <= 6'd0;
`endif
    end else begin
      we_q      <= 1'b0;
      ack_q     <= 1'b0;
      invalid_q <= 1'b0;
      if (end_dir_d) begin
        if (dir_q != 3'd7) begin
          dir_q   <= dir_q + 3'd1;
          k_q     <= 4'd1;
          addr_q  <= next_dir_addr_d;
          state_q <= S_STEP_RD;
        end else if (any_flip_d) begin
          addr_q  <= {y_q, x_q};
          we_q    <= 1'b1;
          wdata_q <= own_d;
          state_q <= S_COMMIT;
        end else begin
          invalid_q <= 1'b1;
          state_q   <= S_REJECT;
        end
      end else begin
        case (state_q)
          S_IDLE: begin
            if (place && new_move) begin
              x_q        <= move_x;
              y_q        <= move_y;
              player_q   <= player;
              any_flip_q <= 1'b0;
`ifdef MOVE_ENGINE_FLIP_COUNT_EN
              flip_cnt_q <= 6'd0;
`endif
              addr_q     <= {move_y, move_x};
              state_q    <= S_TGT_RD;
            end
          end
          S_TGT_RD: state_q <= S_TGT_EV;
          S_TGT_EV: begin
            if ((board_rdata == 2'b01) || (board_rdata == 2'b10)) begin
              invalid_q <= 1'b1;
              state_q   <= S_REJECT;
            end else begin
              dir_q   <= 3'd0;
              k_q     <= 4'd1;
              addr_q  <= first_addr_d;
              state_q <= S_STEP_RD;
            end
          end
          S_STEP_RD: state_q <= S_STEP_EV;
          S_STEP_EV: begin
            if (board_rdata == opp_d) begin
              k_q     <= k_q + 4'd1;
              addr_q  <= inc_addr_d;
              state_q <= S_STEP_RD;
            end else begin
              // Own colour beyond at least one opponent: flip back toward the target.
              k_q     <= k_q - 4'd1;
              addr_q  <= dec_addr_d;
              we_q    <= 1'b1;
              wdata_q <= own_d;
              state_q <= S_FLIP;
            end
          end
          S_FLIP: begin
            k_q    <= k_q - 4'd1;
            addr_q <= dec_addr_d;
            we_q   <= 1'b1;
          end
          S_COMMIT: begin
            ack_q   <= 1'b1;
            state_q <= S_ACK;
          end
          S_ACK, S_REJECT: state_q <= S_IDLE;
          default: state_q <= S_IDLE;
        endcase
      end
      if (state_q == S_FLIP) begin
        any_flip_q <= 1'b1;
`ifdef MOVE_ENGINE_FLIP_COUNT_EN
        flip_cnt_q <= flip_cnt_q + 6'd1;
`endif
      end
    end
  end

  assign board_addr  = addr_q;
  assign board_we    = we_q;
  assign board_wdata = wdata_q;
  assign ack         = ack_q;
  assign invalid     = invalid_q;
  assign busy        = (state_q != S_IDLE);
`ifdef MOVE_ENGINE_FLIP_COUNT_EN
  assign flip_count  = flip_cnt_q;
`endif

endmodule

// File: tb/tb_move_engine.sv
// Bench for move_engine: board RAM model plus an Othello rule/cycle-cost reference, directed and random moves.
module tb_move_engine;
  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       new_move = 1'b0;
  logic       player = 1'b0;
  logic       place = 1'b0;
  logic [2:0] move_x = 3'd0;
  logic [2:0] move_y = 3'd0;
  logic [5:0] board_addr;
  logic [1:0] board_rdata;
  logic       board_we;
  logic [1:0] board_wdata;
  logic       ack, invalid, busy;
`ifdef MOVE_ENGINE_FLIP_COUNT_EN
  logic [5:0] flip_count;
`endif

  int checks = 0;
  int errors = 0;

  logic [1:0] mem   [64];
  logic [1:0] img   [64];
  logic [1:0] exp_b [64];
  logic       load = 1'b0;

  int dxs[8] = '{0, 1, 1, 1, 0, -1, -1, -1};
  int dys[8] = '{-1, -1, 0, 1, 1, 1, 0, -1};

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (load) mem <= img;
    else if (board_we) mem[board_addr] <= board_wdata;
    board_rdata <= mem[board_addr];
  end

  move_engine dut (
    .clock(clock), .reset(reset), .new_move(new_move), .player(player), .place(place),
    .move_x(move_x), .move_y(move_y), .board_addr(board_addr), .board_rdata(board_rdata),
    .board_we(board_we), .board_wdata(board_wdata), .ack(ack), .invalid(invalid), .busy(busy)
`ifdef MOVE_ENGINE_FLIP_COUNT_EN
    , .flip_count(flip_count)
`endif
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] pack_mem();
    logic [127:0] v;
    for (int i = 0; i < 64; i++) v[2*i +: 2] = mem[i];
    return v;
  endfunction

  function automatic logic [127:0] pack_exp();
    logic [127:0] v;
    for (int i = 0; i < 64; i++) v[2*i +: 2] = exp_b[i];
    return v;
  endfunction

  task automatic clear_img();
    for (int i = 0; i < 64; i++) img[i] = 2'b00;
  endtask

  task automatic opening_img();
    clear_img();
    img[4*8+3] = 2'b01;
    img[3*8+4] = 2'b01;
    img[3*8+3] = 2'b10;
    img[4*8+4] = 2'b10;
  endtask

  task automatic load_board();
    @(negedge clock); load = 1'b1;
    @(negedge clock); load = 1'b0;
  endtask

  // Othello rules on exp_b; cyc is the cycle (counted from acceptance) in which ack/invalid appears.
  task automatic ref_move(input int x, input int y, input int p,
                          output bit ok, output int flips, output int cyc);
    logic [1:0] own, opp, v;
    int k, cx, cy;
    own = (p != 0) ? 2'b10 : 2'b01;
    opp = (p != 0) ? 2'b01 : 2'b10;
    flips = 0;
    ok = 1'b0;
    v = exp_b[y*8+x];
    if (v == 2'b01 || v == 2'b10) begin
      cyc = 3;
      return;
    end
    cyc = 2;
    for (int d = 0; d < 8; d++) begin
      k = 1;
      forever begin
        cx = x + k*dxs[d];
        cy = y + k*dys[d];
        if (cx < 0 || cx > 7 || cy < 0 || cy > 7) begin
          cyc += 1;
          break;
        end
        cyc += 2;
        v = exp_b[cy*8+cx];
        if (v == opp) begin
          k++;
          continue;
        end
        if (v == own && k >= 2) begin
          for (int j = 1; j < k; j++) exp_b[(y + j*dys[d])*8 + (x + j*dxs[d])] = own;
          flips += k - 1;
          cyc += k - 1;
        end
        break;
      end
    end
    if (flips > 0) begin
      exp_b[y*8+x] = own;
      ok = 1'b1;
      cyc += 2;
    end else begin
      cyc += 1;
    end
  endtask

  task automatic do_move(input int x, input int y, input int p, input bit noise);
    bit ok, got_ack, got_inv;
    int flips, cyc_exp, cyc, writes;
    logic [127:0] exp_vec;
    for (int i = 0; i < 64; i++) exp_b[i] = mem[i];
    ref_move(x, y, p, ok, flips, cyc_exp);
    exp_vec = pack_exp();
    @(negedge clock);
    move_x = 3'(x); move_y = 3'(y); player = p[0];
    place = 1'b1; new_move = 1'b1;
    @(negedge clock);
    place = 1'b0;
    if (noise) new_move = 1'($urandom_range(0, 1));
    cyc = 1; writes = 0; got_ack = 1'b0; got_inv = 1'b0;
    while (cyc < 400) begin
      if (board_we) writes++;
      if (ack || invalid) begin
        got_ack = ack;
        got_inv = invalid;
        break;
      end
      place = noise && ($urandom_range(0, 4) == 0);
      @(negedge clock);
      cyc++;
    end
    place = 1'b0;
    new_move = 1'b0;
    $display("move (%0d,%0d) p=%0d: ack=%0b invalid=%0b cycle=%0d writes=%0d (model ok=%0b flips=%0d cycle=%0d)",
             x, y, p, got_ack, got_inv, cyc, writes, ok, flips, cyc_exp);
    check("outcome", 128'({got_ack, got_inv}), 128'({ok, !ok}));
    check("latency", 128'(cyc), 128'(cyc_exp));
    check("writes", 128'(writes), ok ? 128'(flips + 1) : 128'(0));
`ifdef MOVE_ENGINE_FLIP_COUNT_EN
    check("flip_count", 128'(flip_count), 128'(flips));
`endif
    @(negedge clock);
    check("after", 128'({busy, ack, invalid, board_we}), 128'(0));
    check("board", pack_mem(), exp_vec);
  endtask

  initial begin
    int n, r, t;
    bit seen;
    clear_img();
    repeat (3) @(negedge clock);
    check("reset_outs", 128'({board_addr, board_we, board_wdata, ack, invalid, busy}), 128'(0));
`ifdef MOVE_ENGINE_FLIP_COUNT_EN
    check("reset_flip_count", 128'(flip_count), 128'(0));
`endif
    reset = 1'b1;

    opening_img(); load_board(); do_move(2, 3, 0, 1'b0);
    opening_img(); load_board(); do_move(3, 3, 0, 1'b0);
    opening_img(); load_board(); do_move(0, 0, 0, 1'b0);

    clear_img();
    img[1*8+2] = 2'b10; img[1*8+3] = 2'b10; img[1*8+4] = 2'b01;
    img[2*8+1] = 2'b10; img[3*8+1] = 2'b01;
    load_board(); do_move(1, 1, 0, 1'b0);

    // place without new_move must not start anything
    opening_img(); load_board();
    @(negedge clock); move_x = 3'd2; move_y = 3'd3; player = 1'b0; new_move = 1'b0; place = 1'b1;
    @(negedge clock); place = 1'b0;
    seen = 1'b0;
    repeat (4) begin
      seen = seen | busy | board_we | ack | invalid;
      @(negedge clock);
    end
    $display("gating: activity=%0b", seen);
    check("gating", 128'(seen), 128'(0));

    opening_img(); load_board(); do_move(2, 3, 0, 1'b1);

    // reset during the first flip write
    opening_img(); load_board();
    @(negedge clock); move_x = 3'd2; move_y = 3'd3; player = 1'b0; new_move = 1'b1; place = 1'b1;
    @(negedge clock); place = 1'b0;
    n = 0;
    while (!board_we && n < 100) begin
      @(negedge clock);
      n++;
    end
    check("flip_seen", 128'(board_we), 128'(1));
    reset = 1'b0;
    @(negedge clock);
    $display("reset mid-flip: busy=%0b we=%0b ack=%0b", busy, board_we, ack);
    check("reset_mid", 128'({busy, board_we, ack, invalid}), 128'(0));
    reset = 1'b1; new_move = 1'b0;
    opening_img(); load_board(); do_move(2, 3, 0, 1'b0);

    repeat (60) begin
      for (int i = 0; i < 64; i++) begin
        r = $urandom_range(0, 9);
        img[i] = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
      end
      t = $urandom_range(0, 63);
      if ($urandom_range(0, 3) != 0) img[t] = ($urandom_range(0, 3) == 0) ? 2'b11 : 2'b00;
      load_board();
      do_move(t % 8, t / 8, $urandom_range(0, 1), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/move_engine.md
# move_engine

Executes one player's move on the Othello board when the main game controller enables it. Latches the cursor coordinates and player colour, checks the target cell, and scans all eight directions in the board RAM. It writes every flanked opponent disc and then the placed disc. It reports the result to the main controller as a one-cycle `ack` for a committed move or `invalid` for a rejected one; the controller uses `ack` to hand the turn to the other player.

## Interface
- No parameters. The board is fixed at 8x8 with 2-bit cells: 00 empty, 01 black, 10 white, 11 treated as empty.
- `clock`  in  1  system clock.
- `reset`  in  1  reset; synchronous, active-low.
- `new_move`  in  1  enable from the main controller; a move is accepted only while high.
- `player`  in  1  0 = black (colour 01), 1 = white (colour 10).
- `place`  in  1  single-cycle, pre-synchronised user request.
- `move_x`, `move_y`  in  3 each  target column and row.
- `board_addr`  out  6  board RAM address, formed as {y,x}.
- `board_rdata`  in  2  RAM read data, valid one cycle after the address is driven.
- `board_we`  out  1  RAM write enable.
- `board_wdata`  out  2  RAM write data.
- `ack`  out  1  one-cycle pulse: move committed.
- `invalid`  out  1  one-cycle pulse: move rejected, board unchanged.
- `busy`  out  1  high in every state except S_IDLE.

## Operation
- States: S_IDLE, S_TGT_RD, S_TGT_EV, S_STEP_RD, S_STEP_EV, S_FLIP, S_COMMIT, S_ACK, S_REJECT.
- **S_IDLE**
  - If `place && new_move`, latch x, y, player and clear the `any_flip` flag, then go to S_TGT_RD.
  - `place` is ignored in every other state.
- **S_TGT_RD**: drive `board_addr` with the target, then go to S_TGT_EV.
- **S_TGT_EV**
  - If `board_rdata` is 01 or 10, go to S_REJECT.
  - Otherwise set dir=0, k=1 and go to S_STEP_RD.
- **Direction order**: dir 0..7 is N, NE, E, SE, S, SW, W, NW. N means y-1. Position = target + k·(dx,dy).
- **S_STEP_RD**
  - If the position is off-board (x or y outside 0..7, computed in 4-bit signed arithmetic), end the direction with no read.
  - Otherwise drive the address and go to S_STEP_EV.
- **S_STEP_EV**
  - Opponent colour: k++ and go to S_STEP_RD.
  - Own colour with k≥2: k-- and go to S_FLIP.
  - Any other value: end the direction.
- **S_FLIP**
  - Assert `board_we`, address = position(k), wdata = own colour, set `any_flip`.
  - If k==1, end the direction; otherwise k--.
- **End of direction**
  - If dir<7: dir++, k=1, go to S_STEP_RD.
  - If dir==7: go to S_COMMIT when `any_flip` is set, else S_REJECT.
- **S_COMMIT**: write own colour to the target, then go to S_ACK.
- **S_ACK**: `ack`=1, return to S_IDLE.
- **S_REJECT**: `invalid`=1, return to S_IDLE.
- **`new_move` deasserted mid-operation**: ignored; the operation runs to completion.
- **Rejected moves**: the board is never written.
- **Reset mid-operation**: the FSM returns to S_IDLE. Writes already made remain in RAM; the init path rebuilds the board.

## Timing
- Reset values: `board_addr`=0, `board_we`=0, `board_wdata`=0, `ack`=0, `invalid`=0, `busy`=0; FSM in S_IDLE.
- `board_we` and `board_addr` are registered outputs, asserted in the cycle the state is active.
- Read data is sampled in the cycle after the address is driven.
- Cost per unit of work:
  - in-board step: 2 cycles;
  - off-board direction end: 1 cycle;
  - flip: 1 cycle per disc.
- Worst case ≈ 3 + 8·(2·7+1) + 48 + 2 ≈ 173 cycles.
- `ack` and `invalid` are mutually exclusive and never high in consecutive cycles.
- `busy` falls in the cycle after `ack` or `invalid`.

## Configuration
- `MOVE_ENGINE_FLIP_COUNT_EN`
  - **Defined**: adds output `flip_count` [5:0]. It is cleared at acceptance, incremented on each S_FLIP, and holds its value until the next acceptance. Reset value is 0.
  - **Undefined**: the port and counter do not exist; all other behaviour is identical.

## Test plan
- **Standard opening, one flip**: B at (3,4),(4,3); W at (3,3),(4,4). Black (`player`=0) places at (2,3) -> (3,3) becomes 01, (2,3) becomes 01, one `ack` pulse, `flip_count`=1, no `invalid`.
- **Occupied target**: place at (3,3) -> `invalid` at cycle 3 after acceptance, zero `board_we` pulses.
- **Empty target with no flank**: opening board, place at (0,0) -> `invalid`, zero writes, corner directions end without reads.
- **Multi-direction flip**: white lines through the target in E (2 discs) and S (1 disc) are capped by black. Black places -> exactly 3 flip writes plus 1 target write, `flip_count`=3, then `ack`.
- **Gating**: `place` with `new_move`=0 -> stays in S_IDLE. `place` while `busy` -> ignored; only one `ack` is produced.
- **Reset mid-flip**: assert `reset` low during S_FLIP -> next cycle `busy`=0, `board_we`=0, `ack`=0; a fresh move afterwards completes normally.
